// File: rtl/wb_stream_writer_fifo.sv
// Output stage of the Wishbone stream writer: buffers WB_DW-bit words in a FIFO
// and splits each one into WB_DW/STREAM_DW stream beats, least-significant lane first.
module wb_stream_writer_fifo #(
    parameter int WB_DW     = 32,
    parameter int FIFO_AW   = 4,
    parameter int STREAM_DW = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [WB_DW-1:0]     fifo_d,
    input  logic                 fifo_wr,
    output logic [FIFO_AW:0]     fifo_cnt,
    output logic [STREAM_DW-1:0] stream_m_data_o,
    output logic                 stream_m_valid_o,
    input  logic                 stream_m_ready_i,
    output logic                 overflow_o
);

    localparam int RATIO = WB_DW / STREAM_DW;
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [LW-1:0]    LAST_LANE = LW'(RATIO - 1);
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    generate
        if (FIFO_AW < 1) begin : g_bad_fifo_aw
            $error("wb_stream_writer_fifo: FIFO_AW must be greater than 0");
        end
        if ((STREAM_DW < 1) || (WB_DW % STREAM_DW != 0)) begin : g_bad_stream_dw
            $error("wb_stream_writer_fifo: WB_DW must be a multiple of STREAM_DW");
        end
    endgenerate

    logic [WB_DW-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [LW-1:0]      lane;
    // Holds the word being split; the current beat always sits in the low lane.
    logic [WB_DW-1:0]   word_q;
    logic [WB_DW-1:0]   word_shifted;

    logic beat_taken;
    logic last_beat;
    logic out_free;
    logic pop;
    logic wr_ok;
    logic drop;

    // NOTE: always_comb assigns every output first so no path can infer a latch.
    always_comb begin
        beat_taken = 1'b0;
        last_beat  = 1'b0;
        out_free   = 1'b0;
        pop        = 1'b0;
        wr_ok      = 1'b0;
        drop       = 1'b0;

        beat_taken = stream_m_valid_o & stream_m_ready_i;
        last_beat  = beat_taken & (lane == LAST_LANE);
        out_free   = ~stream_m_valid_o | last_beat;
        pop        = (fifo_cnt != '0) & out_free;
        // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
        wr_ok      = fifo_wr & ((fifo_cnt != FULL_CNT) | pop);
        drop       = fifo_wr & ~wr_ok;
    end

    generate
        if (RATIO > 1) begin : g_shift
            assign word_shifted = {{STREAM_DW{1'b0}}, word_q[WB_DW-1:STREAM_DW]};
        end else begin : g_no_shift
            assign word_shifted = word_q;
        end
    endgenerate

    // NOTE: the storage array has no reset; only pointers and counters define its contents.
    always_ff @(posedge wb_clk_i) begin
        if (wr_ok) begin
            mem[wr_ptr] <= fifo_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_cnt         <= '0;
            lane             <= '0;
            word_q           <= '0;
            stream_m_valid_o <= 1'b0;
            overflow_o       <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end

            case ({wr_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (pop) begin
                word_q           <= mem[rd_ptr];
                lane             <= '0;
                stream_m_valid_o <= 1'b1;
            end else if (beat_taken) begin
                word_q <= word_shifted;
                lane   <= last_beat ? '0 : lane + LW'(1);
                if (last_beat) begin
                    stream_m_valid_o <= 1'b0;
                end
            end

            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign stream_m_data_o = word_q[STREAM_DW-1:0];

endmodule

// File: tb/tb_wb_stream_writer_fifo.sv
// Directed and randomized bench for wb_stream_writer_fifo: an 8-bit-lane instance
// with a 4-deep FIFO, plus a whole-word (RATIO=1) instance.
module tb_wb_stream_writer_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WB_DW=32, STREAM_DW=8, FIFO_AW=2
    logic        rst;
    logic        wr;
    logic        ready;
    logic [31:0] d;
    logic [2:0]  cnt;
    logic [7:0]  data;
    logic        valid;
    logic        ovf;

    // Instance B: WB_DW=32, STREAM_DW=32, FIFO_AW=2
    logic        rst_b;
    logic        wr_b;
    logic        ready_b;
    logic [31:0] d_b;
    logic [2:0]  cnt_b;
    logic [31:0] data_b;
    logic        valid_b;
    logic        ovf_b;

    wb_stream_writer_fifo #(.WB_DW(32), .FIFO_AW(2), .STREAM_DW(8)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .fifo_d(d), .fifo_wr(wr), .fifo_cnt(cnt),
        .stream_m_data_o(data), .stream_m_valid_o(valid), .stream_m_ready_i(ready),
        .overflow_o(ovf)
    );

    wb_stream_writer_fifo #(.WB_DW(32), .FIFO_AW(2), .STREAM_DW(32)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst_b), .fifo_d(d_b), .fifo_wr(wr_b), .fifo_cnt(cnt_b),
        .stream_m_data_o(data_b), .stream_m_valid_o(valid_b), .stream_m_ready_i(ready_b),
        .overflow_o(ovf_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;

    logic [7:0]  exp_q  [$];
    logic [31:0] exp_qb [$];

    bit         stall_a = 1'b0;
    logic [7:0] stall_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic reset_a();
        rst   = 1'b1;
        wr    = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain_a(input string tag, input int limit);
        ready = 1'b1;
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        check(tag, 32'(exp_q.size()), 0);
    endtask

    // Scoreboard and stream-stability monitor for instance A, sampled mid-cycle.
    always @(negedge clk) begin
        if (stall_a) begin
            check("stall_valid_held", 32'(valid), 1);
            check("stall_data_held", 32'(data), 32'(stall_data));
        end
        if (valid && ready) begin
            n_beats++;
            if (exp_q.size() == 0) check("sb_extra_beat", 32'(exp_q.size()), 1);
            else check("sb_data", 32'(data), 32'(exp_q.pop_front()));
        end
        stall_a    = valid && !ready && !rst;
        stall_data = data;
    end

    always @(negedge clk) begin
        if (valid_b && ready_b) begin
            if (exp_qb.size() == 0) check("sb_b_extra_beat", 32'(exp_qb.size()), 1);
            else check("sb_b_data", data_b, exp_qb.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w_tab [6];
        logic [31:0] w;
        int          sent;
        int          beats_before;
        int          max_cnt;

        w_tab[0] = 32'hA3A2A1A0;
        w_tab[1] = 32'hB3B2B1B0;
        w_tab[2] = 32'hC3C2C1C0;
        w_tab[3] = 32'hD3D2D1D0;
        w_tab[4] = 32'hE3E2E1E0;
        w_tab[5] = 32'hF3F2F1F0;

        rst = 1'b1; wr = 1'b0; ready = 1'b0; d = '0;
        rst_b = 1'b1; wr_b = 1'b0; ready_b = 1'b0; d_b = '0;
        tick();
        tick();
        rst = 1'b0;
        rst_b = 1'b0;

        // Reset state
        check("rst_cnt", 32'(cnt), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_b_cnt", 32'(cnt_b), 0);
        check("rst_b_valid", 32'(valid_b), 0);

        // 1: single word, sink always ready
        ready = 1'b1;
        w = 32'h44332211;
        d = w; wr = 1'b1; push_word(w);
        tick();
        wr = 1'b0;
        check("t1_cnt_after_wr", 32'(cnt), 1);
        check("t1_valid_after_wr", 32'(valid), 0);
        tick();
        check("t1_cnt_after_pop", 32'(cnt), 0);
        for (int i = 0; i < 4; i++) begin
            check("t1_valid_lane", 32'(valid), 1);
            check("t1_data_lane", 32'(data), 32'(w[i*8 +: 8]));
            tick();
        end
        check("t1_valid_end", 32'(valid), 0);

        // 2: sink stalled, fill storage then overflow
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = w_tab[i]; wr = 1'b1; push_word(w_tab[i]);
            tick();
        end
        check("t2_cnt_full", 32'(cnt), 4);
        check("t2_valid", 32'(valid), 1);
        check("t2_data_lane0", 32'(data), 32'h000000A0);
        check("t2_ovf_before", 32'(ovf), 0);
        d = w_tab[5]; wr = 1'b1;
        tick();
        wr = 1'b0;
        check("t2_ovf_set", 32'(ovf), 1);
        check("t2_cnt_after_drop", 32'(cnt), 4);
        tick();
        check("t2_ovf_sticky", 32'(ovf), 1);

        // 3: write into a full FIFO in the cycle the last lane is accepted
        reset_a();
        check("t3_rst_ovf", 32'(ovf), 0);
        check("t3_rst_cnt", 32'(cnt), 0);
        for (int i = 0; i < 5; i++) begin
            d = w_tab[i]; wr = 1'b1; push_word(w_tab[i]);
            tick();
        end
        wr = 1'b0;
        check("t3_cnt_full", 32'(cnt), 4);
        ready = 1'b1;
        tick();
        tick();
        tick();
        check("t3_data_lane3", 32'(data), 32'h000000A3);
        d = w_tab[5]; wr = 1'b1; push_word(w_tab[5]);
        tick();
        wr = 1'b0;
        check("t3_cnt_stays_full", 32'(cnt), 4);
        check("t3_ovf_clear", 32'(ovf), 0);
        check("t3_valid_kept", 32'(valid), 1);
        check("t3_next_word_lane0", 32'(data), 32'h000000B0);
        drain_a("t3_drain", 100);
        check("t3_valid_drained", 32'(valid), 0);
        check("t3_cnt_drained", 32'(cnt), 0);

        // 4: random writes and backpressure over 10000 words
        sent = 0;
        max_cnt = 0;
        beats_before = n_beats;
        while (sent < 10000) begin
            wr = ($urandom_range(0, 3) != 0) && (cnt < 3'd4);
            if (wr) begin
                d = $urandom;
                push_word(d);
                sent++;
            end
            ready = ($urandom_range(0, 7) != 0);
            tick();
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        end
        wr = 1'b0;
        drain_a("t4_drain", 200);
        check("t4_beat_count", 32'(n_beats - beats_before), 40000);
        check("t4_cnt_in_range", 32'(max_cnt <= 4), 1);
        check("t4_ovf_clear", 32'(ovf), 0);
        check("t4_valid_end", 32'(valid), 0);

        // 5: reset in the middle of a word
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = w_tab[i]; wr = 1'b1; push_word(w_tab[i]);
            tick();
        end
        wr = 1'b0;
        check("t5_cnt3", 32'(cnt), 3);
        ready = 1'b1;
        tick();
        tick();
        check("t5_data_lane2", 32'(data), 32'h000000A2);
        rst = 1'b1;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("t5_valid_cleared", 32'(valid), 0);
        check("t5_cnt_cleared", 32'(cnt), 0);
        check("t5_ovf_cleared", 32'(ovf), 0);
        check("t5_data_cleared", 32'(data), 0);
        w = 32'h5A6B7C8D;
        d = w; wr = 1'b1; push_word(w);
        tick();
        wr = 1'b0;
        tick();
        check("t5_restart_valid", 32'(valid), 1);
        check("t5_restart_lane0", 32'(data), 32'h0000008D);
        drain_a("t5_drain", 50);
        check("t5_valid_end", 32'(valid), 0);

        // 6: RATIO=1, continuous writes with the sink always ready
        ready_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d_b = $urandom;
            wr_b = 1'b1;
            exp_qb.push_back(d_b);
            tick();
            check("t6_cnt_le1", 32'(cnt_b), 1);
            check("t6_valid_sustained", 32'(valid_b), 32'(i >= 1));
        end
        wr_b = 1'b0;
        tick();
        check("t6_cnt_empty", 32'(cnt_b), 0);
        check("t6_valid_last", 32'(valid_b), 1);
        tick();
        check("t6_valid_end", 32'(valid_b), 0);
        check("t6_sb_empty", 32'(exp_qb.size()), 0);
        check("t6_ovf_clear", 32'(ovf_b), 0);

        check("end_sb_a_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
